morra_cinese_param: RTL and testbench
=====================================

Name: morra_cinese_param

Overview:
Parametrised next-generation rock-paper-scissors ("morra cinese") referee for two players. It adds a per-round valid handshake, a configurable minimum length and win margin, an early-termination rule, and exposes the round count and advantage. START latches the game length; the block then scores rounds and reports round and game results on registered outputs. It sits beside the player-input logic as the game-control block.

Parameters:
MIN_ROUNDS, 4, minimum number of counted rounds before a game may end; must be >= 1.
WIN_MARGIN, 2, absolute advantage that ends the game early once MIN_ROUNDS is reached; must be >= 1.
CNT_W, $clog2(MIN_ROUNDS+16), localparam, width of the round counters.

Ports:
clk  in  1  clock, rising edge.
RST  in  1  reset, asynchronous, active-high: one clock, async active-high reset.
START  in  1  synchronous game start/restart; priority over all other inputs.
MOVE_VALID  in  1  P1/P2 carry a round this cycle; ignored outside PLAY.
P1  in  2  player-1 move: 00 none, 01 rock, 10 paper, 11 scissors; at START, high bits of length extension.
P2  in  2  player-2 move, same coding; at START, low bits of length extension.
ROUND  out  2  last round result: 00 void, 01 P1, 10 P2, 11 draw.
ROUND_VALID  out  1  one-cycle pulse; ROUND is updated this cycle.
GAME  out  2  00 in progress/none, 01 P1 wins, 10 P2 wins, 11 draw.
BUSY  out  1  high in PLAY.
PLAYED  out  CNT_W  counted (non-void) rounds this game.
ADV  out  CNT_W+1  signed; P1 wins minus P2 wins.

Behaviour:
- RST (any time): state IDLE; all outputs 0; internal TO_PLAY, previous winner and previous winning move cleared.
- States: IDLE, PLAY, DONE. IDLE -> PLAY on START. PLAY -> DONE on game end. DONE -> PLAY on START. Without START, IDLE and DONE hold.
- START (any state, clocked): TO_PLAY = MIN_ROUNDS + {P1,P2} (0..15 extension); PLAYED, ADV, ROUND, GAME, ROUND_VALID and previous winner/move cleared; state PLAY next cycle. MOVE_VALID in the same cycle is ignored.
- PLAY with MOVE_VALID=1: results are registered with 1-cycle latency (the edge that samples the move also updates ROUND, PLAYED and ADV, with ROUND_VALID=1).
- Void (ROUND=00): P1==00 or P2==00 (plus the optional rule). PLAYED, ADV and previous winner are unchanged.
- Winner tables: P1 wins on {P1,P2} = 0111, 1001, 1110 -> ADV+1. P2 wins on 1101, 0110, 1011 -> ADV-1. Both players win records prev winner and move. Equal moves give a draw (11): PLAYED+1, ADV unchanged, prev winner cleared.
- End check uses the updated values on the same edge. The game ends if PLAYED >= MIN_ROUNDS and either |ADV| >= WIN_MARGIN or PLAYED == TO_PLAY.
- On end: GAME = 01 if ADV>0, 10 if ADV<0, 11 if ADV==0, set on the same edge as the final ROUND; state DONE.
- Before MIN_ROUNDS, |ADV| may exceed WIN_MARGIN; there is no early end. Counters never wrap because TO_PLAY <= MIN_ROUNDS+15 fits in CNT_W.
- DONE: GAME, ROUND, PLAYED and ADV hold; ROUND_VALID=0; MOVE_VALID is ignored.
- ROUND_VALID is 0 in every cycle without a processed move.

Optional Feature:
MORRA_NO_REPEAT_EN: when defined, a round is void if the previous round winner plays the same move it won with (prev winner 01 and P1 == prev move, or prev winner 10 and P2 == prev move). When undefined, that rule is absent and such rounds are scored normally.

Decomposition:
- Package morra_pkg holds:
  - move_t enum (NONE, ROCK, PAPER, SCISSORS);
  - result_t enum (VOID, P1_WIN, P2_WIN, DRAW);
  - state_t enum (IDLE, PLAY, DONE).
- One combinational sub-module, morra_round_judge: inputs P1, P2, prev winner and prev move; output result_t.

Test Plan:
- RST; START with P1=00, P2=00 (TO_PLAY=4); rounds 01/11, 10/01, 11/10, 01/11 -> ROUND=01 each round, ADV=4 at PLAYED=4, GAME=01 on the 4th ROUND_VALID, BUSY drops.
- START P1=00, P2=10 (TO_PLAY=6); alternate P1 and P2 wins for 6 rounds -> no end at PLAYED=4 (ADV=0), GAME=11 at PLAYED=6.
- In PLAY, a move with P1=00 -> ROUND=00, ROUND_VALID=1, PLAYED and ADV unchanged; MOVE_VALID=0 cycles -> ROUND_VALID=0.
- Assert RST mid-game, between clock edges -> all outputs 0 immediately; MOVE_VALID is then ignored until START.
- P1 wins with 01 vs 11, then plays 01 vs 11 again -> ROUND=00 with MORRA_NO_REPEAT_EN defined, ROUND=01 without it.
- In DONE, MOVE_VALID is ignored and GAME holds. START together with MOVE_VALID restarts the game, the move is ignored, and GAME=00 on the next cycle.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared types for the morra_cinese_param referee.
//   move_t   : 2-bit player move coding (NONE, ROCK, PAPER, SCISSORS)
//   result_t : per-round result coding (VOID, P1_WIN, P2_WIN, DRAW)
//   state_t  : referee FSM states (IDLE, PLAY, DONE)
//   beats()  : true when move a defeats move b
package morra_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    ROCK     = 2'b01,
    PAPER    = 2'b10,
    SCISSORS = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    VOID   = 2'b00,
    P1_WIN = 2'b01,
    P2_WIN = 2'b10,
    DRAW   = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic beats(input move_t a, input move_t b);
    return ((a == ROCK)     && (b == SCISSORS)) ||
           ((a == PAPER)    && (b == ROCK))     ||
           ((a == SCISSORS) && (b == PAPER));
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational judge for a single round.
// Optional feature macro: MORRA_NO_REPEAT_EN (previous winner may not repeat its winning move).
// Ports:
//   p1_i, p2_i      : player moves
//   prev_winner_i   : winner of the previous counted round (VOID when none/draw)
//   prev_move_i     : move the previous winner won with
//   result_o        : VOID, P1_WIN, P2_WIN or DRAW
module morra_round_judge
  import morra_pkg::*;
(
  input  move_t   p1_i,
  input  move_t   p2_i,
  input  result_t prev_winner_i,
  input  move_t   prev_move_i,
  output result_t result_o
);

  logic repeat_void;

`ifdef MORRA_NO_REPEAT_EN
  assign repeat_void = ((prev_winner_i == P1_WIN) && (p1_i == prev_move_i)) ||
                       ((prev_winner_i == P2_WIN) && (p2_i == prev_move_i));
`else
  logic unused_prev;
  assign unused_prev = ^{prev_winner_i, prev_move_i};
  assign repeat_void = 1'b0;
`endif

  always_comb begin
    result_o = VOID;
    if ((p1_i == NONE) || (p2_i == NONE) || repeat_void) begin
      result_o = VOID;
    end else if (p1_i == p2_i) begin
      result_o = DRAW;
    end else if (beats(p1_i, p2_i)) begin
      result_o = P1_WIN;
    end else begin
      result_o = P2_WIN;
    end
  end

endmodule

// File: rtl/morra_cinese_param.sv
// Parametrised two-player rock-paper-scissors referee.
// Optional feature macro: MORRA_NO_REPEAT_EN (see morra_round_judge).
// Ports:
//   clk, RST (async, active-high)
//   START       : start/restart; {P1,P2} give a 0..15 length extension
//   MOVE_VALID  : P1/P2 carry a round (PLAY only)
//   P1, P2      : moves
//   ROUND       : last round result; ROUND_VALID pulses when it updates
//   GAME        : game result (00 while in progress)
//   BUSY        : high in PLAY
//   PLAYED      : counted (non-void) rounds
//   ADV         : signed P1 wins minus P2 wins
module morra_cinese_param
  import morra_pkg::*;
#(
  parameter int unsigned MIN_ROUNDS = 4,
  parameter int unsigned WIN_MARGIN = 2,
  localparam int unsigned CNT_W     = $clog2(MIN_ROUNDS + 16)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               START,
  input  logic               MOVE_VALID,
  input  logic [1:0]         P1,
  input  logic [1:0]         P2,
  output logic [1:0]         ROUND,
  output logic               ROUND_VALID,
  output logic [1:0]         GAME,
  output logic               BUSY,
  output logic [CNT_W-1:0]   PLAYED,
  output logic [CNT_W:0]     ADV
);

  localparam logic signed [CNT_W:0] AdvOne = (CNT_W + 1)'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        to_play_q, to_play_d;
  logic [CNT_W-1:0]        played_q, played_d;
  logic signed [CNT_W:0]   adv_q, adv_d;
  logic [CNT_W:0]          adv_mag;
  result_t                 round_q, round_d;
  logic                    round_valid_q, round_valid_d;
  logic [1:0]              game_q, game_d;
  result_t                 prev_win_q, prev_win_d;
  move_t                   prev_move_q, prev_move_d;
  result_t                 judge_res;

  morra_round_judge u_judge (
    .p1_i          (move_t'(P1)),
    .p2_i          (move_t'(P2)),
    .prev_winner_i (prev_win_q),
    .prev_move_i   (prev_move_q),
    .result_o      (judge_res)
  );

  always_comb begin
    state_d       = state_q;
    to_play_d     = to_play_q;
    played_d      = played_q;
    adv_d         = adv_q;
    round_d       = round_q;
    round_valid_d = 1'b0;
    game_d        = game_q;
    prev_win_d    = prev_win_q;
    prev_move_d   = prev_move_q;
    adv_mag       = '0;

    if (START) begin
      to_play_d   = CNT_W'(MIN_ROUNDS) + CNT_W'({P1, P2});
      played_d    = '0;
      adv_d       = '0;
      round_d     = VOID;
      game_d      = 2'b00;
      prev_win_d  = VOID;
      prev_move_d = NONE;
      state_d     = PLAY;
    end else if ((state_q == PLAY) && MOVE_VALID) begin
      round_d       = judge_res;
      round_valid_d = 1'b1;
      unique case (judge_res)
        P1_WIN: begin
          played_d    = played_q + 1'b1;
          adv_d       = adv_q + AdvOne;
          prev_win_d  = P1_WIN;
          prev_move_d = move_t'(P1);
        end
        P2_WIN: begin
          played_d    = played_q + 1'b1;
          adv_d       = adv_q - AdvOne;
          prev_win_d  = P2_WIN;
          prev_move_d = move_t'(P2);
        end
        DRAW: begin
          played_d    = played_q + 1'b1;
          prev_win_d  = VOID;
          prev_move_d = NONE;
        end
        default: ;
      endcase

      // End check looks at the values being written on this same edge.
      adv_mag = adv_d[CNT_W] ? $unsigned(-adv_d) : $unsigned(adv_d);
      if ((played_d >= CNT_W'(MIN_ROUNDS)) &&
          ((adv_mag >= (CNT_W + 1)'(WIN_MARGIN)) || (played_d == to_play_q))) begin
        state_d = DONE;
        if (adv_d[CNT_W])     game_d = 2'b10;
        else if (adv_d == '0) game_d = 2'b11;
        else                  game_d = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      to_play_q     <= '0;
      played_q      <= '0;
      adv_q         <= '0;
      round_q       <= VOID;
      round_valid_q <= 1'b0;
      game_q        <= 2'b00;
      prev_win_q    <= VOID;
      prev_move_q   <= NONE;
    end else begin
      state_q       <= state_d;
      to_play_q     <= to_play_d;
      played_q      <= played_d;
      adv_q         <= adv_d;
      round_q       <= round_d;
      round_valid_q <= round_valid_d;
      game_q        <= game_d;
      prev_win_q    <= prev_win_d;
      prev_move_q   <= prev_move_d;
    end
  end

  assign ROUND       = round_q;
  assign ROUND_VALID = round_valid_q;
  assign GAME        = game_q;
  assign BUSY        = (state_q == PLAY);
  assign PLAYED      = played_q;
  assign ADV         = adv_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
module tb_morra_cinese_param;

  localparam int CW = 5;  // $clog2(4 + 16) for the default MIN_ROUNDS

  logic          clk = 1'b0;
  logic          RST, START, MOVE_VALID;
  logic [1:0]    P1, P2, ROUND, GAME;
  logic          ROUND_VALID, BUSY;
  logic [CW-1:0] PLAYED;
  logic [CW:0]   ADV;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  morra_cinese_param dut (
    .clk         (clk),
    .RST         (RST),
    .START       (START),
    .MOVE_VALID  (MOVE_VALID),
    .P1          (P1),
    .P2          (P2),
    .ROUND       (ROUND),
    .ROUND_VALID (ROUND_VALID),
    .GAME        (GAME),
    .BUSY        (BUSY),
    .PLAYED      (PLAYED),
    .ADV         (ADV)
  );

  typedef struct {
    logic       start;
    logic       mv;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] round;
    logic       rv;
    logic [1:0] game;
    logic       busy;
    int         played;
    int         adv;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic mv, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] er, input logic erv,
                              input logic [1:0] eg, input logic eb, input int ep,
                              input int ea);
    vec_t v;
    v.start = s;  v.mv = mv;  v.p1 = a;  v.p2 = b;
    v.round = er; v.rv = erv; v.game = eg; v.busy = eb;
    v.played = ep; v.adv = ea;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [1:0] er, input logic erv,
                       input logic [1:0] eg, input logic eb, input int ep, input int ea);
    logic [CW-1:0] p;
    logic [CW:0]   a;
    p = ep[CW-1:0];
    a = ea[CW:0];
    n_run++;
    if ({ROUND, ROUND_VALID, GAME, BUSY, PLAYED, ADV} !== {er, erv, eg, eb, p, a}) begin
      n_fail++;
      $display("FAIL %s: got round=%b rv=%b game=%b busy=%b played=%0d adv=%0d, want round=%b rv=%b game=%b busy=%b played=%0d adv=%0d",
               name, ROUND, ROUND_VALID, GAME, BUSY, PLAYED, $signed(ADV),
               er, erv, eg, eb, ep, ea);
    end
  endtask

  task automatic step(input logic s, input logic mv, input logic [1:0] a, input logic [1:0] b);
    START = s; MOVE_VALID = mv; P1 = a; P2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Game 1: TO_PLAY=4, P1 wins every round; ADV passes margin before MIN_ROUNDS.
    add(1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0);
    add(0, 1, 2'b01, 2'b11, 2'b01, 1, 2'b00, 1, 1, 1);
    add(0, 1, 2'b10, 2'b01, 2'b01, 1, 2'b00, 1, 2, 2);
    add(0, 1, 2'b11, 2'b10, 2'b01, 1, 2'b00, 1, 3, 3);
    add(0, 1, 2'b01, 2'b11, 2'b01, 1, 2'b01, 0, 4, 4);
    add(0, 0, 2'b00, 2'b00, 2'b01, 0, 2'b01, 0, 4, 4);
    add(0, 1, 2'b01, 2'b11, 2'b01, 0, 2'b01, 0, 4, 4);  // DONE ignores moves
    // Game 2: START with MOVE_VALID from DONE, TO_PLAY=6, alternating winners.
    add(1, 1, 2'b00, 2'b10, 2'b00, 0, 2'b00, 1, 0, 0);
    add(0, 1, 2'b11, 2'b01, 2'b10, 1, 2'b00, 1, 1, -1);
    add(0, 1, 2'b01, 2'b11, 2'b01, 1, 2'b00, 1, 2, 0);
    add(0, 1, 2'b10, 2'b11, 2'b10, 1, 2'b00, 1, 3, -1);
    add(0, 1, 2'b10, 2'b01, 2'b01, 1, 2'b00, 1, 4, 0);  // no end at MIN_ROUNDS
    add(0, 1, 2'b00, 2'b01, 2'b00, 1, 2'b00, 1, 4, 0);  // void round
    add(0, 0, 2'b01, 2'b11, 2'b00, 0, 2'b00, 1, 4, 0);  // no move, no pulse
    add(0, 1, 2'b01, 2'b10, 2'b10, 1, 2'b00, 1, 5, -1);
    add(0, 1, 2'b01, 2'b11, 2'b01, 1, 2'b11, 0, 6, 0);  // TO_PLAY reached, draw
    // Game 3: repeated winning move, then a draw and another P1 win.
    add(1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0);
    add(0, 1, 2'b01, 2'b11, 2'b01, 1, 2'b00, 1, 1, 1);
`ifdef MORRA_NO_REPEAT_EN
    add(0, 1, 2'b01, 2'b11, 2'b00, 1, 2'b00, 1, 1, 1);
    add(0, 1, 2'b10, 2'b10, 2'b11, 1, 2'b00, 1, 2, 1);
    add(0, 1, 2'b01, 2'b11, 2'b01, 1, 2'b00, 1, 3, 2);
`else
    add(0, 1, 2'b01, 2'b11, 2'b01, 1, 2'b00, 1, 2, 2);
    add(0, 1, 2'b10, 2'b10, 2'b11, 1, 2'b00, 1, 3, 2);
    add(0, 1, 2'b01, 2'b11, 2'b01, 1, 2'b01, 0, 4, 3);
`endif
    // Restart with a simultaneous move; the move must be ignored.
    add(1, 1, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1, 0, 0);

    RST = 1'b1; START = 1'b0; MOVE_VALID = 1'b0; P1 = 2'b00; P2 = 2'b00;
    #12;
    check("reset", 2'b00, 0, 2'b00, 0, 0, 0);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].start, vecs[i].mv, vecs[i].p1, vecs[i].p2);
      check($sformatf("vec%0d", i), vecs[i].round, vecs[i].rv, vecs[i].game,
            vecs[i].busy, vecs[i].played, vecs[i].adv);
    end

    // Asynchronous reset mid-game, between clock edges.
    step(0, 1, 2'b01, 2'b11);
    check("pre_rst", 2'b01, 1, 2'b00, 1, 1, 1);
    START = 1'b0; MOVE_VALID = 1'b0;
    #3;
    RST = 1'b1;
    #1;
    check("async_rst", 2'b00, 0, 2'b00, 0, 0, 0);
    @(posedge clk);
    #1;
    RST = 1'b0;
    step(0, 1, 2'b01, 2'b11);
    check("idle_ignores_move", 2'b00, 0, 2'b00, 0, 0, 0);

    // Maximum length extension: TO_PLAY = 4 + 15 = 19, all draws.
    step(1, 0, 2'b11, 2'b11);
    check("start_max", 2'b00, 0, 2'b00, 1, 0, 0);
    for (int i = 1; i <= 19; i++) begin
      step(0, 1, 2'b10, 2'b10);
      if (i < 19) check($sformatf("draw%0d", i), 2'b11, 1, 2'b00, 1, i, 0);
      else        check("draw_end", 2'b11, 1, 2'b11, 0, 19, 0);
    end
    step(0, 0, 2'b00, 2'b00);
    check("done_hold", 2'b11, 0, 2'b11, 0, 19, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
